// File: rtl/render_pkg.sv
// render_pkg: shared widths, vertex/index typedefs and buffer state encoding
package render_pkg;
  localparam int DATA_W = 24;
  localparam int MAX_VERTS = 32768;
  localparam int IDX_W = $clog2(MAX_VERTS);
  typedef logic [2:0][DATA_W-1:0] vertex_t;
  typedef logic [2:0][IDX_W-1:0] index_triple_t;
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
endpackage

// File: rtl/model_buffer_if.sv
// model_buffer_if: load, stream and status signals of the model buffer
interface model_buffer_if;
  import render_pkg::*;
  logic i_load_clear;
  logic i_load_vertex_en;
  vertex_t i_load_vertex;
  logic i_load_index_en;
  index_triple_t i_load_index;
  logic i_load_commit;
  logic i_vertex_read_en;
  vertex_t o_vertex;
  logic o_vertex_dv;
  logic o_vertex_last;
  logic i_index_read_en;
  index_triple_t o_index_data;
  logic o_index_dv;
  logic o_index_last;
  logic o_ready;
  logic o_load_err;
  logic o_read_err;
  modport master (
    output i_load_clear, i_load_vertex_en, i_load_vertex, i_load_index_en, i_load_index,
           i_load_commit, i_vertex_read_en, i_index_read_en,
    input  o_vertex, o_vertex_dv, o_vertex_last, o_index_data, o_index_dv, o_index_last,
           o_ready, o_load_err, o_read_err
  );
  modport slave (
    input  i_load_clear, i_load_vertex_en, i_load_vertex, i_load_index_en, i_load_index,
           i_load_commit, i_vertex_read_en, i_index_read_en,
    output o_vertex, o_vertex_dv, o_vertex_last, o_index_data, o_index_dv, o_index_last,
           o_ready, o_load_err, o_read_err
  );
endinterface

// File: rtl/sam_channel.sv
// sam_channel: append-write store with wrapping sequential registered read
module sam_channel #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          dv,
  output logic          last,
  output logic [CW-1:0] count,
  output logic          full
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic at_end;
  assign full = count == CW'(DEPTH);
  assign at_end = CW'(ptr) == count - 1'b1;
  // storage has no reset so it maps onto block RAM; stale data is unreachable once count is zero
  always_ff @(posedge clk)
    if (wr_en) mem[count[PW-1:0]] <= wr_data;
  // fill level: next append address
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) count <= '0;
    else if (clear) count <= '0;
    else if (wr_en) count <= count + 1'b1;
  // one registered read per request, pointer wraps after the last entry
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      ptr <= '0;
      dv <= 1'b0;
      last <= 1'b0;
      rd_data <= '0;
    end else if (clear) begin
      ptr <= '0;
      dv <= 1'b0;
      last <= 1'b0;
    end else begin
      dv <= rd_en;
      last <= rd_en && at_end;
      if (rd_en) begin
        rd_data <= mem[ptr];
        ptr <= at_end ? '0 : ptr + 1'b1;
      end
    end
endmodule

// File: rtl/model_buffer.sv
// model_buffer: vertex/index model store with load FSM and streaming readout
module model_buffer
  import render_pkg::*;
#(
  parameter int DATAWIDTH = DATA_W,
  parameter int MAX_VERTEX_COUNT = MAX_VERTS,
  parameter int MAX_TRIANGLE_COUNT = 32768
) (
  input logic clk,
  input logic rstn,
  model_buffer_if.slave bus
);
  localparam int VCW = $clog2(MAX_VERTEX_COUNT + 1);
  localparam int ICW = $clog2(MAX_TRIANGLE_COUNT + 1);
  state_t state;
  logic [VCW-1:0] v_cnt;
  logic [ICW-1:0] i_cnt;
  logic v_full, i_full, v_wr, i_wr, v_rd, i_rd, loadable, clr, commit_ok, load_bad;
  assign clr = bus.i_load_clear;
  assign loadable = state != READY;
  assign v_wr = !clr && loadable && bus.i_load_vertex_en && !v_full;
  assign i_wr = !clr && loadable && bus.i_load_index_en && !i_full;
  assign v_rd = !clr && state == READY && bus.i_vertex_read_en;
  assign i_rd = !clr && state == READY && bus.i_index_read_en;
  assign commit_ok = !clr && loadable && bus.i_load_commit && (v_cnt != '0 || v_wr) && (i_cnt != '0 || i_wr);
  assign load_bad = (bus.i_load_vertex_en && !v_wr) || (bus.i_load_index_en && !i_wr)
                  || (loadable && bus.i_load_commit && !commit_ok);
  // load/commit state machine with registered status pulses; clear overrides everything
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= EMPTY;
      bus.o_ready <= 1'b0;
      bus.o_load_err <= 1'b0;
      bus.o_read_err <= 1'b0;
    end else begin
      state <= clr ? EMPTY : commit_ok ? READY : (state == EMPTY && (v_wr || i_wr)) ? LOADING : state;
      bus.o_ready <= !clr && (commit_ok || state == READY);
      bus.o_load_err <= !clr && load_bad;
      bus.o_read_err <= !clr && !(state == READY) && (bus.i_vertex_read_en || bus.i_index_read_en);
    end
  sam_channel #(.W(3 * DATAWIDTH), .DEPTH(MAX_VERTEX_COUNT)) u_vertex (
    .clk(clk), .rstn(rstn), .clear(clr),
    .wr_en(v_wr), .wr_data(bus.i_load_vertex),
    .rd_en(v_rd), .rd_data(bus.o_vertex), .dv(bus.o_vertex_dv), .last(bus.o_vertex_last),
    .count(v_cnt), .full(v_full)
  );
  sam_channel #(.W(3 * IDX_W), .DEPTH(MAX_TRIANGLE_COUNT)) u_index (
    .clk(clk), .rstn(rstn), .clear(clr),
    .wr_en(i_wr), .wr_data(bus.i_load_index),
    .rd_en(i_rd), .rd_data(bus.o_index_data), .dv(bus.o_index_dv), .last(bus.o_index_last),
    .count(i_cnt), .full(i_full)
  );
endmodule

// File: tb/tb_model_buffer.sv
// tb_model_buffer: queue-based reference model, directed scenarios and random traffic
module tb_model_buffer;
  import render_pkg::*;
  localparam int MAXV = 4;
  localparam int MAXI = 6;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  model_buffer_if bus ();
  model_buffer #(.DATAWIDTH(DATA_W), .MAX_VERTEX_COUNT(MAXV), .MAX_TRIANGLE_COUNT(MAXI)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vertex_t vx(input int x, input int y, input int z);
    vertex_t v;
    v[0] = DATA_W'(x);
    v[1] = DATA_W'(y);
    v[2] = DATA_W'(z);
    return v;
  endfunction
  function automatic index_triple_t ix(input int a, input int b, input int c);
    index_triple_t t;
    t[0] = IDX_W'(a);
    t[1] = IDX_W'(b);
    t[2] = IDX_W'(c);
    return t;
  endfunction
  vertex_t vq[$];
  index_triple_t iq[$];
  int ms = 0;
  int vp = 0;
  int ip = 0;
  logic e_ready = 0, e_lerr = 0, e_rerr = 0, e_vdv = 0, e_vlast = 0, e_idv = 0, e_ilast = 0;
  vertex_t e_v = '0;
  index_triple_t e_i = '0;
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      ms = 0; vq.delete(); iq.delete(); vp = 0; ip = 0;
      {e_ready, e_lerr, e_rerr, e_vdv, e_vlast, e_idv, e_ilast} = '0;
      e_v = '0; e_i = '0;
    end else begin
      {e_lerr, e_rerr, e_vdv, e_vlast, e_idv, e_ilast} = '0;
      if (bus.i_load_clear) begin
        ms = 0; vq.delete(); iq.delete(); vp = 0; ip = 0;
      end else if (ms == 2) begin
        if (bus.i_load_vertex_en || bus.i_load_index_en) e_lerr = 1;
        if (bus.i_vertex_read_en) begin
          e_vdv = 1; e_v = vq[vp]; e_vlast = vp == vq.size() - 1; vp = (vp + 1) % vq.size();
        end
        if (bus.i_index_read_en) begin
          e_idv = 1; e_i = iq[ip]; e_ilast = ip == iq.size() - 1; ip = (ip + 1) % iq.size();
        end
      end else begin
        if (bus.i_load_vertex_en) begin
          if (vq.size() < MAXV) vq.push_back(bus.i_load_vertex); else e_lerr = 1;
        end
        if (bus.i_load_index_en) begin
          if (iq.size() < MAXI) iq.push_back(bus.i_load_index); else e_lerr = 1;
        end
        if (ms == 0 && (vq.size() > 0 || iq.size() > 0)) ms = 1;
        if (bus.i_load_commit) begin
          if (vq.size() > 0 && iq.size() > 0) ms = 2; else e_lerr = 1;
        end
        if (bus.i_vertex_read_en || bus.i_index_read_en) e_rerr = 1;
      end
      e_ready = ms == 2;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("ready", bus.o_ready, e_ready);
    chk("load_err", bus.o_load_err, e_lerr);
    chk("read_err", bus.o_read_err, e_rerr);
    chk("vertex_dv", bus.o_vertex_dv, e_vdv);
    chk("vertex_last", bus.o_vertex_last, e_vlast);
    chk("vertex", bus.o_vertex, e_v);
    chk("index_dv", bus.o_index_dv, e_idv);
    chk("index_last", bus.o_index_last, e_ilast);
    chk("index", bus.o_index_data, e_i);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.i_load_clear = 0; bus.i_load_vertex_en = 0; bus.i_load_vertex = '0;
    bus.i_load_index_en = 0; bus.i_load_index = '0; bus.i_load_commit = 0;
    bus.i_vertex_read_en = 0; bus.i_index_read_en = 0;
  endtask
  task automatic wr_v(input vertex_t v);
    bus.i_load_vertex_en = 1; bus.i_load_vertex = v; tick(); bus.i_load_vertex_en = 0;
  endtask
  task automatic wr_i(input index_triple_t t);
    bus.i_load_index_en = 1; bus.i_load_index = t; tick(); bus.i_load_index_en = 0;
  endtask
  task automatic commit();
    bus.i_load_commit = 1; tick(); bus.i_load_commit = 0;
  endtask
  initial begin
    vertex_t exp_v [4];
    logic [95:0] rnd;
    idle();
    repeat (2) tick();
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_vertex", bus.o_vertex, 0);
    rstn = 1;
    wr_v(vx(1, 2, 3)); wr_v(vx(4, 5, 6)); wr_v(vx(7, 8, 9));
    wr_i(ix(0, 1, 2));
    commit();
    chk("commit_ready", bus.o_ready, 1);
    wr_v(vx(10, 10, 10));
    chk("ready_write_err", bus.o_load_err, 1);
    chk("ready_kept", bus.o_ready, 1);
    exp_v[0] = vx(1, 2, 3); exp_v[1] = vx(4, 5, 6); exp_v[2] = vx(7, 8, 9); exp_v[3] = vx(1, 2, 3);
    bus.i_vertex_read_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_dv", bus.o_vertex_dv, 1);
      chk("stream_data", bus.o_vertex, exp_v[k]);
      chk("stream_last", bus.o_vertex_last, k == 2);
    end
    bus.i_vertex_read_en = 0;
    tick();
    chk("idle_dv", bus.o_vertex_dv, 0);
    chk("idle_hold", bus.o_vertex, vx(1, 2, 3));
    bus.i_load_clear = 1; bus.i_vertex_read_en = 1;
    tick();
    idle();
    chk("clear_dv", bus.o_vertex_dv, 0);
    chk("clear_ready", bus.o_ready, 0);
    bus.i_vertex_read_en = 1; tick(); bus.i_vertex_read_en = 0;
    chk("empty_read_err", bus.o_read_err, 1);
    wr_v(vx(1, 1, 1)); wr_v(vx(2, 2, 2));
    commit();
    chk("no_index_err", bus.o_load_err, 1);
    chk("no_index_ready", bus.o_ready, 0);
    bus.i_index_read_en = 1; tick(); bus.i_index_read_en = 0;
    chk("load_read_err", bus.o_read_err, 1);
    chk("load_read_dv", bus.o_index_dv, 0);
    wr_v(vx(3, 3, 3)); wr_v(vx(4, 4, 4));
    chk("fourth_ok", bus.o_load_err, 0);
    wr_v(vx(5, 5, 5));
    chk("full_err", bus.o_load_err, 1);
    wr_i(ix(3, 2, 1));
    commit();
    chk("full_ready", bus.o_ready, 1);
    bus.i_vertex_read_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_last", bus.o_vertex_last, k == 3);
    end
    chk("full_data", bus.o_vertex, vx(4, 4, 4));
    bus.i_index_read_en = 1;
    tick(); tick();
    chk("both_vdv", bus.o_vertex_dv, 1);
    chk("both_idv", bus.o_index_dv, 1);
    #2 rstn = 0;
    #1;
    chk("arst_vdv", bus.o_vertex_dv, 0);
    chk("arst_vlast", bus.o_vertex_last, 0);
    chk("arst_idv", bus.o_index_dv, 0);
    chk("arst_ilast", bus.o_index_last, 0);
    chk("arst_ready", bus.o_ready, 0);
    chk("arst_errs", {bus.o_load_err, bus.o_read_err}, 0);
    tick();
    rstn = 1;
    tick();
    chk("post_rst_err", bus.o_read_err, 1);
    chk("post_rst_dv", {bus.o_vertex_dv, bus.o_index_dv}, 0);
    idle();
    for (int c = 0; c < 3000; c++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      bus.i_load_clear = $urandom_range(0, 99) < 2;
      bus.i_load_vertex_en = $urandom_range(0, 2) == 0;
      bus.i_load_vertex = rnd[71:0];
      bus.i_load_index_en = $urandom_range(0, 2) == 0;
      bus.i_load_index = rnd[95:51];
      bus.i_load_commit = $urandom_range(0, 9) == 0;
      bus.i_vertex_read_en = $urandom_range(0, 1) == 1;
      bus.i_index_read_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 799) == 0) rstn = 0;
      tick();
      rstn = 1;
    end
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
